// File: rtl/gps_acq_pkg.sv
// Shared types and constants for the GPS acquisition scheduler.
// Optional peak-ratio detection is enabled by defining GPS_ACQ_PEAK_RATIO_EN.
package gps_acq_pkg;

  localparam int NUM_PRN      = 32;
  localparam int PRN_W        = 6;
  localparam int CODE_PHASE_W = 10;
  localparam int DOPPLER_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LAUNCH,
    WAIT,
    REPORT,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/gps_acq_scheduler_if.sv
// Per-satellite detection result port of the acquisition scheduler.
// res_second exists only when GPS_ACQ_PEAK_RATIO_EN is defined.
interface gps_acq_scheduler_if
  import gps_acq_pkg::*;
#(
  parameter int PWR_W = 16
) ();

  // Handshake: a result transfers on a cycle where res_valid && res_ready.
  // Once raised, res_valid and every res_* field stay stable until that cycle.
  logic                          res_valid;
  logic                          res_ready;
  logic [PRN_W-1:0]              res_sat;
  logic [CODE_PHASE_W-1:0]       res_code_phase;
  logic signed [DOPPLER_W-1:0]   res_doppler;
  logic [PWR_W-1:0]              res_peak;
  logic                          res_detected;
  logic                          res_timeout;
`ifdef GPS_ACQ_PEAK_RATIO_EN
  logic [PWR_W-1:0]              res_second;
`endif

  modport master (
    output res_valid, res_sat, res_code_phase, res_doppler, res_peak,
           res_detected, res_timeout,
`ifdef GPS_ACQ_PEAK_RATIO_EN
           res_second,
`endif
    input  res_ready
  );

  modport slave (
    input  res_valid, res_sat, res_code_phase, res_doppler, res_peak,
           res_detected, res_timeout,
`ifdef GPS_ACQ_PEAK_RATIO_EN
           res_second,
`endif
    output res_ready
  );

endinterface

// File: rtl/gps_prn_pick.sv
// Lowest-set-bit priority encoder: picks the next PRN (index+1) from a pending mask.
module gps_prn_pick
  import gps_acq_pkg::*;
(
  input  logic [NUM_PRN-1:0] mask,
  output logic [PRN_W-1:0]   prn,
  output logic [4:0]         idx,
  output logic               none
);

  always_comb begin
    idx  = '0;
    none = (mask == '0);
    // Descending scan so the lowest set bit is the last (winning) assignment.
    for (int i = NUM_PRN - 1; i >= 0; i--) begin
      if (mask[i]) idx = 5'(i);
    end
    prn = none ? '0 : ({1'b0, idx} + 6'd1);
  end

endmodule

// File: rtl/gps_acq_scheduler.sv
// Steps the correlator engine through the selected PRNs, tracks the peak power per
// satellite and reports one result each. GPS_ACQ_PEAK_RATIO_EN adds a peak/second ratio test.
module gps_acq_scheduler
  import gps_acq_pkg::*;
#(
  parameter int PWR_W       = 16,
  parameter int TIMEOUT_CYC = 2**26,
  parameter int TO_W        = 27
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_PRN-1:0]          sat_mask,
  input  logic [PWR_W-1:0]            threshold,
  output logic                        busy,
  output logic                        done,
  output logic                        eng_start,
  output logic [PRN_W-1:0]            eng_sat,
  input  logic                        eng_corr_complete,
  input  logic [CODE_PHASE_W-1:0]     eng_code_phase,
  input  logic signed [DOPPLER_W-1:0] eng_doppler,
  input  logic [PWR_W-1:0]            eng_power,
  input  logic                        eng_search_complete,
  gps_acq_scheduler_if.master         res,
  output sched_state_t                dbg_state
);

  sched_state_t                state, state_nxt;
  logic [NUM_PRN-1:0]          mask_r;
  logic [PWR_W-1:0]            thr_r, peak_r, pk_nxt;
  logic [CODE_PHASE_W-1:0]     cp_r, cp_nxt;
  logic signed [DOPPLER_W-1:0] dop_r, dop_nxt;
  logic                        valid_pk, vpk_nxt;
  logic [4:0]                  cur_idx, pick_idx;
  logic [PRN_W-1:0]            pick_prn, eng_sat_r;
  logic                        pick_none;
  logic [TO_W-1:0]             wd;
  logic                        cc_q, sc_q, cc_rise, sc_rise;
  logic                        in_wait, cap, timeout_hit, to_report;
  logic                        ratio_ok, det_nxt;

  logic [PRN_W-1:0]            rs_sat;
  logic [CODE_PHASE_W-1:0]     rs_cp;
  logic signed [DOPPLER_W-1:0] rs_dop;
  logic [PWR_W-1:0]            rs_peak;
  logic                        rs_det, rs_to;

  gps_prn_pick u_pick (
    .mask (mask_r),
    .prn  (pick_prn),
    .idx  (pick_idx),
    .none (pick_none)
  );

  assign cc_rise     = eng_corr_complete & ~cc_q;
  assign sc_rise     = eng_search_complete & ~sc_q;
  assign in_wait     = (state == WAIT);
  // Strict compare: the first of several equal peaks is kept.
  assign cap         = in_wait & cc_rise & (~valid_pk | (eng_power > peak_r));
  assign timeout_hit = in_wait & (wd == TO_W'(TIMEOUT_CYC - 1));
  assign to_report   = in_wait & (sc_rise | timeout_hit);

  // Post-capture peak view, so a capture coinciding with search end is reported.
  always_comb begin
    pk_nxt  = peak_r;
    cp_nxt  = cp_r;
    dop_nxt = dop_r;
    vpk_nxt = valid_pk;
    if (cap) begin
      pk_nxt  = eng_power;
      cp_nxt  = eng_code_phase;
      dop_nxt = eng_doppler;
      vpk_nxt = 1'b1;
    end
  end

`ifdef GPS_ACQ_PEAK_RATIO_EN
  logic [PWR_W-1:0]        sec_r, sec_nxt, rs_second;
  logic [CODE_PHASE_W-1:0] cp_dist;
  logic                    far;
  logic [PWR_W:0]          sec_scaled;

  always_comb begin
    cp_dist = (eng_code_phase > cp_r) ? (eng_code_phase - cp_r) : (cp_r - eng_code_phase);
    far     = (cp_dist > CODE_PHASE_W'(1));
    sec_nxt = sec_r;
    if (in_wait && cc_rise) begin
      if (cap) begin
        if (valid_pk && far) sec_nxt = peak_r;
      end else if (far && (eng_power > sec_r)) begin
        sec_nxt = eng_power;
      end
    end
    sec_scaled = {1'b0, sec_nxt} + {2'b00, sec_nxt[PWR_W-1:1]};
    ratio_ok   = ({1'b0, pk_nxt} >= sec_scaled);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_r     <= '0;
      rs_second <= '0;
    end else if (state == SCAN) begin
      sec_r <= '0;
    end else if (in_wait) begin
      sec_r <= sec_nxt;
      if (to_report) rs_second <= sec_nxt;
    end
  end

  assign res.res_second = rs_second;
`else
  assign ratio_ok = 1'b1;
`endif

  // A watchdog abort (no sc_rise) never reports a detection.
  assign det_nxt = vpk_nxt & (pk_nxt >= thr_r) & ratio_ok & sc_rise;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    state_nxt = pick_none ? FINISH : LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (sc_rise || timeout_hit) state_nxt = REPORT;
      REPORT:  if (res.res_ready) state_nxt = SCAN;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cc_q      <= 1'b0;
      sc_q      <= 1'b0;
      mask_r    <= '0;
      thr_r     <= '0;
      cur_idx   <= '0;
      eng_sat_r <= '0;
      peak_r    <= '0;
      cp_r      <= '0;
      dop_r     <= '0;
      valid_pk  <= 1'b0;
      wd        <= '0;
      rs_sat    <= '0;
      rs_cp     <= '0;
      rs_dop    <= '0;
      rs_peak   <= '0;
      rs_det    <= 1'b0;
      rs_to     <= 1'b0;
    end else begin
      cc_q <= eng_corr_complete;
      sc_q <= eng_search_complete;
      case (state)
        IDLE: if (start) begin
          mask_r <= sat_mask;
          thr_r  <= threshold;
        end
        SCAN: if (!pick_none) begin
          eng_sat_r <= pick_prn;
          cur_idx   <= pick_idx;
          peak_r    <= '0;
          valid_pk  <= 1'b0;
        end
        LAUNCH: wd <= '0;
        WAIT: begin
          wd       <= wd + TO_W'(1);
          peak_r   <= pk_nxt;
          cp_r     <= cp_nxt;
          dop_r    <= dop_nxt;
          valid_pk <= vpk_nxt;
          if (to_report) begin
            rs_sat  <= eng_sat_r;
            rs_cp   <= cp_nxt;
            rs_dop  <= dop_nxt;
            rs_peak <= pk_nxt;
            rs_det  <= det_nxt;
            rs_to   <= ~sc_rise;
          end
        end
        REPORT: if (res.res_ready) mask_r[cur_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy               = (state != IDLE) && (state != FINISH);
  assign done               = (state == FINISH);
  assign eng_start          = (state == LAUNCH);
  assign eng_sat            = eng_sat_r;
  assign dbg_state          = state;
  assign res.res_valid      = (state == REPORT);
  assign res.res_sat        = rs_sat;
  assign res.res_code_phase = rs_cp;
  assign res.res_doppler    = rs_dop;
  assign res.res_peak       = rs_peak;
  assign res.res_detected   = rs_det;
  assign res.res_timeout    = rs_to;

endmodule
